// File: rtl/axis_capture_packer_if.sv
// AXI-Stream bundle shared by the capture packer's sample input and packed-word output.
interface axis_capture_packer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_capture_packer.sv
// Triggered capture of cfg_len 64-bit words, each packing two consecutive 32-bit ADC samples.
// Optional DECIMATION_EN keeps only every (cfg_dec+1)-th accepted sample while capturing.
module axis_capture_packer #(
    parameter int S_TDATA_WIDTH = 32,
    parameter int M_TDATA_WIDTH = 64,
    parameter int CNTR_WIDTH    = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [CNTR_WIDTH-1:0] cfg_len,
    input  logic [15:0]           cfg_dec,
    input  logic                  trg_start,
    output logic [CNTR_WIDTH-1:0] sts_count,
    output logic                  sts_busy,
    axis_capture_packer_if.slave  s_axis,
    axis_capture_packer_if.master m_axis
);
    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    state_t                   state_reg, state_next;
    logic [CNTR_WIDTH-1:0]    len_reg, count_reg, loaded_reg;
    logic [S_TDATA_WIDTH-1:0] low_reg;
    logic                     half_reg;
    logic [M_TDATA_WIDTH-1:0] m_data_reg;
    logic                     m_valid_reg, m_last_reg;
    logic                     s_ready, s_hs, m_hs, start, keep, pack, complete, last_word;

    assign start     = (state_reg == IDLE) && trg_start && (cfg_len != '0);
    assign s_hs      = s_axis.tvalid & s_ready;
    assign m_hs      = m_valid_reg & m_axis.tready;
    assign pack      = (state_reg == CAPTURE) && s_hs && keep;
    assign complete  = pack & half_reg;
    assign last_word = (loaded_reg + CNTR_WIDTH'(1)) == len_reg;

`ifdef DECIMATION_EN
    logic [15:0] dec_reg, dec_cnt_reg;
    logic        unused_inputs;

    assign keep          = (dec_cnt_reg == 16'd0);
    assign unused_inputs = s_axis.tlast;

    // Counter runs over every accepted capture sample; zero marks the one that is packed.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            dec_reg     <= 16'd0;
            dec_cnt_reg <= 16'd0;
        end else if (start) begin
            dec_reg     <= cfg_dec;
            dec_cnt_reg <= 16'd0;
        end else if ((state_reg == CAPTURE) && s_hs) begin
            dec_cnt_reg <= (dec_cnt_reg == dec_reg) ? 16'd0 : dec_cnt_reg + 16'd1;
        end
    end
`else
    logic unused_inputs;

    assign keep          = 1'b1;
    assign unused_inputs = ^{cfg_dec, s_axis.tlast};
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CAPTURE;
            CAPTURE: if (complete && last_word) state_next = DRAIN;
            DRAIN:   if (m_hs && m_last_reg) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Only a word-completing sample can stall, and only while the held word is not leaving.
    always_comb begin
        s_ready  = 1'b1;
        sts_busy = 1'b0;
        case (state_reg)
            CAPTURE: begin
                s_ready  = ~(half_reg & m_valid_reg & ~m_axis.tready);
                sts_busy = 1'b1;
            end
            DRAIN:   sts_busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            len_reg     <= '0;
            count_reg   <= '0;
            loaded_reg  <= '0;
            low_reg     <= '0;
            half_reg    <= 1'b0;
            m_data_reg  <= '0;
            m_valid_reg <= 1'b0;
            m_last_reg  <= 1'b0;
        end else begin
            if (start) begin
                len_reg    <= cfg_len;
                count_reg  <= '0;
                loaded_reg <= '0;
                half_reg   <= 1'b0;
            end else begin
                if (m_hs && (count_reg != len_reg))
                    count_reg <= count_reg + CNTR_WIDTH'(1);
                if (pack) begin
                    half_reg <= ~half_reg;
                    if (!half_reg) begin
                        low_reg <= s_axis.tdata;
                    end else begin
                        m_data_reg <= {s_axis.tdata, low_reg};
                        loaded_reg <= loaded_reg + CNTR_WIDTH'(1);
                    end
                end
            end
            // A new word may replace the one handshaken in the same cycle.
            if (complete) begin
                m_valid_reg <= 1'b1;
                m_last_reg  <= last_word;
            end else if (m_hs) begin
                m_valid_reg <= 1'b0;
                m_last_reg  <= 1'b0;
            end
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = m_data_reg;
    assign m_axis.tvalid = m_valid_reg;
    assign m_axis.tlast  = m_last_reg;
    assign sts_count     = count_reg;
endmodule

// File: tb/tb_axis_capture_packer.sv
// Directed bench for axis_capture_packer: queue-based reference model checked every cycle plus literal word checks.
module tb_axis_capture_packer;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] cfg_len;
    logic [15:0] cfg_dec;
    logic        trg_start;
    logic [31:0] sts_count;
    logic        sts_busy;

    always #5 aclk = ~aclk;

    axis_capture_packer_if #(.WIDTH(32)) s_if();
    axis_capture_packer_if #(.WIDTH(64)) m_if();

    assign s_if.tlast = 1'b0;

    axis_capture_packer dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .cfg_len   (cfg_len),
        .cfg_dec   (cfg_dec),
        .trg_start (trg_start),
        .sts_count (sts_count),
        .sts_busy  (sts_busy),
        .s_axis    (s_if),
        .m_axis    (m_if)
    );

    int total_cnt = 0;
    int pass_cnt  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: capture window, list of packed samples, one output slot.
    bit          busy_m = 0, cap_m = 0, oval_m = 0, olast_m = 0;
    int unsigned len_m = 0, count_m = 0, loaded_m = 0, acc_m = 0, dec_m = 0;
    logic [31:0] q_m[$];
    logic [63:0] odata_m = 64'd0;
    logic [63:0] got_data[$];
    bit          got_last[$];

    initial begin
        bit exp_sready, s_hs, keep, was_busy;
        forever begin
            @(negedge aclk);
            exp_sready = !(cap_m && (q_m.size() % 2 == 1) && oval_m && !m_if.tready);
            chk("s_tready", 64'(s_if.tready), 64'(exp_sready));
            chk("m_tvalid", 64'(m_if.tvalid), 64'(oval_m));
            chk("sts_busy", 64'(sts_busy), 64'(busy_m));
            chk("sts_count", 64'(sts_count), 64'(count_m));
            if (oval_m) begin
                chk("m_tdata", m_if.tdata, odata_m);
                chk("m_tlast", 64'(m_if.tlast), 64'(olast_m));
            end
            s_hs = s_if.tvalid && s_if.tready;
            if (m_if.tvalid && m_if.tready) begin
                got_data.push_back(m_if.tdata);
                got_last.push_back(m_if.tlast);
            end
            if (!aresetn) begin
                busy_m = 0; cap_m = 0; oval_m = 0; olast_m = 0;
                len_m = 0; count_m = 0; loaded_m = 0; odata_m = 64'd0;
                q_m.delete();
            end else begin
                was_busy = busy_m;
                if (oval_m && m_if.tready) begin
                    if (count_m < len_m) count_m++;
                    if (olast_m) begin busy_m = 0; cap_m = 0; end
                    oval_m = 0; olast_m = 0;
                end
                if (cap_m && s_hs) begin
                    keep = 1;
`ifdef DECIMATION_EN
                    keep = (acc_m % (dec_m + 1)) == 0;
`endif
                    acc_m++;
                    if (keep) begin
                        q_m.push_back(s_if.tdata);
                        if (q_m.size() % 2 == 0) begin
                            odata_m = {q_m[$], q_m[$-1]};
                            oval_m  = 1;
                            loaded_m++;
                            olast_m = (loaded_m == len_m);
                            if (olast_m) cap_m = 0;
                        end
                    end
                end
                if (!was_busy && trg_start && cfg_len != 0) begin
                    busy_m = 1; cap_m = 1; len_m = cfg_len; count_m = 0;
                    loaded_m = 0; acc_m = 0; dec_m = 32'(cfg_dec);
                    q_m.delete();
                end
            end
        end
    end

    int unsigned feed_val;
    bit          drv_toggle;

    task automatic tick();
        bit hs;
        @(negedge aclk);
        hs = s_if.tvalid && s_if.tready;
        @(posedge aclk);
        #2;
        if (hs) feed_val++;
        s_if.tdata = feed_val;
        if (drv_toggle) m_if.tready = ~m_if.tready;
    endtask

    task automatic set_feed(input int unsigned v);
        feed_val   = v;
        s_if.tdata = v;
    endtask

    task automatic capture(input int unsigned len, input int unsigned first, input bit toggle);
        cfg_len     = len;
        trg_start   = 1'b1;
        s_if.tvalid = 1'b0;
        tick();
        trg_start   = 1'b0;
        set_feed(first);
        s_if.tvalid = 1'b1;
        drv_toggle  = toggle;
        for (int i = 0; i < 60 && sts_busy; i++) tick();
        chk("capture_end_busy", 64'(sts_busy), 64'd0);
        s_if.tvalid = 1'b0;
        drv_toggle  = 1'b0;
        m_if.tready = 1'b1;
        tick();
    endtask

    task automatic expect_words(input string name, input int base, input int n,
                                input logic [63:0] w0, input logic [63:0] w1,
                                input logic [63:0] w2, input logic [63:0] w3);
        logic [63:0] ew[4];
        ew[0] = w0; ew[1] = w1; ew[2] = w2; ew[3] = w3;
        chk($sformatf("%s_nwords", name), 64'(got_data.size() - base), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < got_data.size()) begin
                chk($sformatf("%s_word%0d", name, i), got_data[base+i], ew[i]);
                chk($sformatf("%s_last%0d", name, i), 64'(got_last[base+i]), 64'(i == n - 1));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        aresetn = 1'b0; cfg_len = 0; cfg_dec = 0; trg_start = 1'b0;
        s_if.tvalid = 1'b0; s_if.tdata = 32'd0; m_if.tready = 1'b1;
        drv_toggle = 1'b0; feed_val = 0;
        repeat (3) tick();
        chk("rst_s_tready", 64'(s_if.tready), 64'd1);
        chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("rst_m_tlast", 64'(m_if.tlast), 64'd0);
        chk("rst_m_tdata", m_if.tdata, 64'd0);
        chk("rst_sts_count", 64'(sts_count), 64'd0);
        chk("rst_sts_busy", 64'(sts_busy), 64'd0);
        aresetn = 1'b1;
        tick();

        base = got_data.size();
        capture(4, 1, 1'b0);
        expect_words("t1", base, 4, 64'h00000002_00000001, 64'h00000004_00000003,
                     64'h00000006_00000005, 64'h00000008_00000007);
        chk("t1_count", 64'(sts_count), 64'd4);

        base = got_data.size();
        capture(4, 1, 1'b1);
        expect_words("t2", base, 4, 64'h00000002_00000001, 64'h00000004_00000003,
                     64'h00000006_00000005, 64'h00000008_00000007);
        chk("t2_count", 64'(sts_count), 64'd4);

        base = got_data.size();
        cfg_len = 0; trg_start = 1'b1; s_if.tvalid = 1'b1; set_feed(32'h50);
        repeat (5) tick();
        trg_start = 1'b0;
        repeat (3) tick();
        chk("t3_len0_busy", 64'(sts_busy), 64'd0);
        chk("t3_len0_nwords", 64'(got_data.size() - base), 64'd0);
        chk("t3_len0_count_hold", 64'(sts_count), 64'd4);

        base = got_data.size();
        cfg_len = 2; set_feed(32'h10); trg_start = 1'b1;
        tick();
        for (int i = 0; i < 40 && sts_busy; i++) tick();
        trg_start = 1'b0;
        repeat (6) tick();
        s_if.tvalid = 1'b0;
        tick();
        expect_words("t3_held", base, 2, 64'h00000012_00000011, 64'h00000014_00000013, 64'd0, 64'd0);
        chk("t3_held_busy", 64'(sts_busy), 64'd0);
        chk("t3_held_count", 64'(sts_count), 64'd2);

        base = got_data.size();
        cfg_len = 2; trg_start = 1'b1; s_if.tvalid = 1'b0;
        tick();
        trg_start = 1'b0; m_if.tready = 1'b0; set_feed(32'h21); s_if.tvalid = 1'b1;
        repeat (3) tick();
        s_if.tvalid = 1'b0;
        aresetn = 1'b0;
        repeat (2) tick();
        chk("t4_rst_s_tready", 64'(s_if.tready), 64'd1);
        chk("t4_rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("t4_rst_m_tlast", 64'(m_if.tlast), 64'd0);
        chk("t4_rst_m_tdata", m_if.tdata, 64'd0);
        chk("t4_rst_count", 64'(sts_count), 64'd0);
        chk("t4_rst_busy", 64'(sts_busy), 64'd0);
        aresetn = 1'b1; m_if.tready = 1'b1;
        tick();
        chk("t4_nwords_dropped", 64'(got_data.size() - base), 64'd0);
        base = got_data.size();
        capture(2, 32'h31, 1'b0);
        expect_words("t4_fresh", base, 2, 64'h00000032_00000031, 64'h00000034_00000033, 64'd0, 64'd0);

`ifdef DECIMATION_EN
        base = got_data.size();
        cfg_dec = 16'd2;
        capture(2, 0, 1'b0);
        expect_words("t5_dec", base, 2, 64'h00000003_00000000, 64'h00000009_00000006, 64'd0, 64'd0);
        cfg_dec = 16'd0;
`endif

        repeat (2) tick();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
